// File: rtl/mileage_display_sched_pkg.sv
// mileage_pkg: shared types and constants for the mileage display scheduler.
//   state_e     - conversion FSM states
//   NDIGITS     - number of displayed BCD digits
//   MAX_MILEAGE - largest displayable record; larger values saturate
//   BCD_W       - width of the packed BCD value
//   bcd_adjust  - double-dabble pre-shift correction (+3 on nibbles >= 5)
package mileage_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StCommit} state_e;

  localparam int unsigned NDIGITS     = 8;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned BCD_W       = NDIGITS * DIGIT_W;
  localparam int unsigned MAX_MILEAGE = 99_999_999;

  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] >= 4'd5) begin
        r[i*DIGIT_W +: DIGIT_W] = v[i*DIGIT_W +: DIGIT_W] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mileage_display_sched_if.sv
// mileage_display_sched_if: request/result/display bundle of the scheduler.
//   power_now, record, upd             - driven by the master (vehicle side)
//   busy, done, ovf, bcd,
//   digit_en, digit_val                - driven by the slave (scheduler)
// REC_W must match the REC_W of the scheduler instance it connects to.
interface mileage_display_sched_if #(
  parameter int unsigned REC_W = 27
);
  logic                             power_now;
  logic [REC_W-1:0]                 record;
  logic                             upd;
  logic                             busy;
  logic                             done;
  logic                             ovf;
  logic [mileage_pkg::BCD_W-1:0]    bcd;
  logic [mileage_pkg::NDIGITS-1:0]  digit_en;
  logic [mileage_pkg::DIGIT_W-1:0]  digit_val;

  modport master (
    output power_now, record, upd,
    input  busy, done, ovf, bcd, digit_en, digit_val
  );

  modport slave (
    input  power_now, record, upd,
    output busy, done, ovf, bcd, digit_en, digit_val
  );
endinterface

// File: rtl/mileage_display_sched_scan_tick.sv
// scan_tick: free-running prescaler, counts 0..SCAN_DIV-1 and wraps.
//   clk    - system clock
//   rst    - synchronous active-high reset (counter to 0)
//   o_tick - high for the one cycle in which the counter wraps
module scan_tick #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == CntW'(SCAN_DIV - 1));
  assign o_tick = w_wrap;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/mileage_display_sched.sv
// mileage_display_sched: converts a binary mileage record to 8-digit BCD
// (double dabble, one bit per cycle) and time-multiplexes the committed
// value onto a one-hot digit scan.
//   clk     - system clock, rising edge
//   rst     - synchronous active-high reset
//   io_bus  - slave side of mileage_display_sched_if (power_now, record, upd
//             in; busy, done, ovf, bcd, digit_en, digit_val out)
// Optional feature macro: MILEAGE_LZ_BLANK_EN - blank leading-zero digits
// above the most significant nonzero digit (digit 0 is always shown).
module mileage_display_sched
  import mileage_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned REC_W    = 27
) (
  input logic                    clk,
  input logic                    rst,
  mileage_display_sched_if.slave io_bus
);

  localparam int unsigned CntW = (REC_W > 1) ? $clog2(REC_W) : 1;
  localparam int unsigned IdxW = $clog2(NDIGITS);

  state_e           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;
  logic             r_ovf_pend;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] r_scr;
  logic [REC_W-1:0] r_bin;
  logic [CntW-1:0]  r_cnt;
  logic [IdxW-1:0]  r_idx;

  logic             w_tick;
  logic [BCD_W-1:0] w_adj;
  logic [63:0]      w_rec_ext;
  logic             w_show;

  scan_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan_tick (
    .clk    (clk),
    .rst    (rst),
    .o_tick (w_tick)
  );

  assign w_adj     = bcd_adjust(r_scr);
  assign w_rec_ext = 64'(r_bin);

  // Power loss has priority over everything but reset: abort without commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_ovf_pend <= 1'b0;
      r_bcd      <= '0;
      r_scr      <= '0;
      r_bin      <= '0;
      r_cnt      <= '0;
    end else if (!io_bus.power_now) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (io_bus.upd) begin
            r_bin   <= io_bus.record;
            r_busy  <= 1'b1;
            r_state <= StLoad;
          end
        end
        StLoad: begin
          r_scr <= '0;
          r_cnt <= '0;
          if (w_rec_ext > 64'(MAX_MILEAGE)) begin
            r_bin      <= REC_W'(MAX_MILEAGE);
            r_ovf_pend <= 1'b1;
          end else begin
            r_ovf_pend <= 1'b0;
          end
          r_state <= StShift;
        end
        StShift: begin
          // Adjust, then shift {scratch, binary} left by one bit.
          r_scr <= {w_adj[BCD_W-2:0], r_bin[REC_W-1]};
          r_bin <= r_bin << 1;
          if (r_cnt == CntW'(REC_W - 1)) begin
            r_busy  <= 1'b0;
            r_state <= StCommit;
          end else begin
            r_cnt <= r_cnt + CntW'(1);
          end
        end
        StCommit: begin
          r_bcd   <= r_scr;
          r_ovf   <= r_ovf_pend;
          r_done  <= 1'b1;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_tick) begin
      r_idx <= r_idx + IdxW'(1);
    end
  end

`ifdef MILEAGE_LZ_BLANK_EN
  logic [IdxW-1:0] w_msd;

  // Index of the most significant nonzero digit; 0 when the value is zero.
  always_comb begin
    w_msd = '0;
    for (int i = 1; i < NDIGITS; i++) begin
      if (r_bcd[i*DIGIT_W +: DIGIT_W] != '0) begin
        w_msd = IdxW'(i);
      end
    end
  end

  assign w_show = io_bus.power_now && (r_idx <= w_msd);
`else
  assign w_show = io_bus.power_now;
`endif

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.ovf       = r_ovf;
  assign io_bus.bcd       = r_bcd;
  assign io_bus.digit_en  = w_show ? (NDIGITS'(1) << r_idx) : '0;
  assign io_bus.digit_val = r_bcd[{r_idx, 2'b00} +: DIGIT_W];

endmodule

// File: tb/tb_mileage_display_sched.sv
// tb_mileage_display_sched: directed self-checking bench for
// mileage_display_sched with a result scoreboard and a scan-index model.
module tb_mileage_display_sched;

  localparam int unsigned ScanDiv = 4;
  localparam int unsigned RecW    = 27;

  logic clk;
  logic rst;

  mileage_display_sched_if #(.REC_W(RecW)) bus ();

  mileage_display_sched #(
    .SCAN_DIV (ScanDiv),
    .REC_W    (RecW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {ovf, bcd} per accepted update, in order.
  logic [32:0] sb[$];

  // Edges since the last reset edge; models the scan index.
  int unsigned sc;
  always @(posedge clk) begin
    if (rst) sc <= 0;
    else     sc <= sc + 1;
  end

  function automatic int unsigned model_idx();
    return (sc / ScanDiv) % 8;
  endfunction

  function automatic logic [32:0] model(input logic [RecW-1:0] rec);
    int unsigned v;
    logic [31:0] b;
    logic        o;
    v = rec;
    o = (v > 99_999_999);
    if (o) v = 99_999_999;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      b[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return {o, b};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int max_edges, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < max_edges && !seen; k++) begin
      step();
      if (bus.done) seen = 1'b1;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic convert(input logic [RecW-1:0] rec, input string tag);
    bus.record = rec;
    bus.upd    = 1'b1;
    sb.push_back(model(rec));
    step();
    bus.upd = 1'b0;
    wait_done(40, tag);
  endtask

  task automatic count_done(input int edges, output int cnt);
    cnt = 0;
    for (int k = 0; k < edges; k++) begin
      step();
      if (bus.done) cnt++;
    end
  endtask

  // Scoreboard side: compare every committed value as it appears.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        check("sb_bcd", 64'(bus.bcd), 64'(e[31:0]));
        check("sb_ovf", 64'(bus.ovf), 64'(e[32]));
        check("sb_digit_val_at_commit", 64'(bus.digit_val),
              64'(e[model_idx()*4 +: 4]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int busy_cnt;
    int done_at;
    int n;
    int pos[$];
    logic [7:0] exp_en;
    int idx;
    logic [31:0] v42;

    rst           = 1'b1;
    bus.power_now = 1'b0;
    bus.upd       = 1'b0;
    bus.record    = '0;

    // Reset state, power off then on.
    step();
    step();
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_bcd", 64'(bus.bcd), 64'd0);
    check("rst_en_pwr0", 64'(bus.digit_en), 64'h00);
    check("rst_val", 64'(bus.digit_val), 64'h0);
    bus.power_now = 1'b1;
    step();
    rst = 1'b0;
    check("rst_en_pwr1", 64'(bus.digit_en), 64'h01);

    // 12_345_678 with a one-cycle upd: done on edge 29, busy for 28 cycles.
    bus.record = 27'd12_345_678;
    bus.upd    = 1'b1;
    sb.push_back(model(27'd12_345_678));
    step();
    bus.upd  = 1'b0;
    busy_cnt = bus.busy ? 1 : 0;
    done_at  = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.busy) busy_cnt++;
      if (bus.done && done_at == 0) done_at = k;
    end
    check("conv_done_edge", 64'(done_at), 64'd29);
    check("conv_busy_cycles", 64'(busy_cnt), 64'd28);
    check("conv_bcd", 64'(bus.bcd), 64'h12345678);

    // Saturation.
    convert(27'h7FFFFFF, "ovf_done");
    check("ovf_bcd", 64'(bus.bcd), 64'h99999999);
    check("ovf_flag", 64'(bus.ovf), 64'd1);

    // Scan order and leading-zero handling for 0x42.
    convert(27'd42, "scan_done");
    v42 = 32'h00000042;
    for (int k = 0; k < 40; k++) begin
      idx = model_idx();
      exp_en = 8'h01 << idx;
`ifdef MILEAGE_LZ_BLANK_EN
      if (idx > 1) exp_en = 8'h00;
`endif
      check("scan_en", 64'(bus.digit_en), 64'(exp_en));
      check("scan_val", 64'(bus.digit_val), 64'(v42[idx*4 +: 4]));
      step();
    end

    // Reset on edge 10 of a conversion.
    bus.record = 27'd555;
    bus.upd    = 1'b1;
    step();
    bus.upd = 1'b0;
    repeat (9) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_bcd", 64'(bus.bcd), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    count_done(40, n);
    check("midrst_no_done", 64'(n), 64'd0);

    // Power loss mid-SHIFT, then upd while unpowered.
    convert(27'd1234, "pwr_pre_done");
    bus.record = 27'd777;
    bus.upd    = 1'b1;
    step();
    bus.upd = 1'b0;
    repeat (4) step();
    bus.power_now = 1'b0;
    #1;
    check("pwr_en_off", 64'(bus.digit_en), 64'h00);
    step();
    check("pwr_busy", 64'(bus.busy), 64'd0);
    check("pwr_bcd_kept", 64'(bus.bcd), 64'h00001234);
    bus.upd = 1'b1;
    repeat (5) step();
    check("pwr_upd_ignored", 64'(bus.busy), 64'd0);
    bus.upd       = 1'b0;
    bus.power_now = 1'b1;
    count_done(40, n);
    check("pwr_no_done", 64'(n), 64'd0);
    check("pwr_bcd_after", 64'(bus.bcd), 64'h00001234);

    // upd held for 100 cycles: commits every 30 cycles.
    bus.record = 27'd31_415_926;
    bus.upd    = 1'b1;
    repeat (4) sb.push_back(model(27'd31_415_926));
    for (int k = 0; k < 130; k++) begin
      step();
      if (k == 99) bus.upd = 1'b0;
      if (bus.done) pos.push_back(k);
    end
    check("hold_count", 64'(pos.size()), 64'd4);
    if (pos.size() > 0) check("hold_first", 64'(pos[0]), 64'd29);
    for (int i = 1; i < pos.size(); i++) begin
      check("hold_spacing", 64'(pos[i] - pos[i-1]), 64'd30);
    end

    // Boundary values.
    convert(27'd0, "zero_done");
    check("zero_bcd", 64'(bus.bcd), 64'h0);
    convert(27'd99_999_999, "max_done");
    check("max_ovf", 64'(bus.ovf), 64'd0);
    convert(27'd100_000_000, "over_done");
    check("over_ovf", 64'(bus.ovf), 64'd1);
    convert(27'd90_807_001, "mix_done");

    step();
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mileage_display_sched.md
MILEAGE_DISPLAY_SCHED -- requirements
Module: mileage_display_sched

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000, clk cycles each digit stays selected (legal range 2..2^20).
REQ-002 SHALL have parameter REC_W, default 27, width of the binary mileage record.
REQ-003 SHALL have a single clock domain; reset is synchronous and active-high.
REQ-004 SHALL have port: clk  in  1  system clock, all logic on rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-006 SHALL have port: power_now  in  1  vehicle powered; 0 blanks display and aborts conversion.
REQ-007 SHALL have port: record  in  REC_W  binary mileage, sampled only on an accepted update.
REQ-008 SHALL have port: upd  in  1  update request, single-cycle or level.
REQ-009 SHALL have port: busy  out  1  conversion in progress.
REQ-010 SHALL have port: done  out  1  one-cycle pulse when a new BCD value is committed.
REQ-011 SHALL have port: ovf  out  1  last committed record exceeded 99_999_999.
REQ-012 SHALL have port: bcd  out  32  committed 8-digit BCD value, digit 7 in [31:28].
REQ-013 SHALL have port: digit_en  out  8  one-hot active-high digit select, bit 0 = least significant digit.
REQ-014 SHALL have port: digit_val  out  4  BCD nibble of the selected digit.

Function
REQ-015 SHALL run an FSM with states IDLE, LOAD, SHIFT, COMMIT.
REQ-016 IDLE: upd=1 and power_now=1 at a clock edge SHALL move to LOAD; record latched on that edge.
REQ-017 LOAD: SHALL clear the scratch BCD register, set shift count 0, and saturate the latched value to 99_999_999 if larger; go to SHIFT.
REQ-018 SHIFT: SHALL perform one double-dabble step per cycle (add 3 to every nibble >=5, then shift left by 1 bit) for exactly REC_W cycles, then go to COMMIT.
REQ-019 COMMIT: SHALL load bcd and ovf, pulse done for one cycle, and return to IDLE.
REQ-020 done SHALL be high exactly REC_W+2 edges after the edge that accepted upd (29 by default); busy SHALL be high in LOAD and SHIFT only.
REQ-021 upd while not in IDLE SHALL be ignored, not queued; upd held high SHALL restart a conversion on the cycle after COMMIT.
REQ-022 power_now=0 in any state SHALL force IDLE on the next edge without committing; bcd and ovf keep their last values.
REQ-023 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap the digit index SHALL advance 0->1->...->7->0.
REQ-024 digit_en SHALL be one-hot at the digit index when power_now=1 and 8'h00 when power_now=0; digit_val SHALL equal the bcd nibble at the index.
REQ-025 bcd changes at COMMIT SHALL take effect on digit_val the same cycle, without resetting the scan index.

Reset
REQ-026 rst=1 at an edge SHALL set state IDLE, busy 0, done 0, ovf 0, bcd 32'h0, scan counter 0, digit index 0; this overrides every other input, including mid-conversion.
REQ-027 After reset, digit_en SHALL be 8'h01 if power_now=1, else 8'h00, and digit_val 4'h0.

Configuration
REQ-028 Macro MILEAGE_LZ_BLANK_EN defined: digit_en SHALL be 8'h00 during slots of digits above the most significant nonzero digit; digit 0 SHALL always be shown.
REQ-029 Macro undefined: all eight digits SHALL be shown, leading zeros included.

Structure
REQ-030 Package mileage_pkg SHALL hold the FSM state enum, NDIGITS=8, MAX_MILEAGE=99_999_999, and the BCD width of 32.
REQ-031 Sub-module scan_tick SHALL hold the SCAN_DIV prescaler and emit a one-cycle wrap tick; the FSM and double-dabble datapath stay in the top module.

Verification
REQ-032 A bench SHALL cover: record=12_345_678 with a one-cycle upd -> done on the 29th edge, bcd=32'h12345678, ovf=0, busy high for 28 cycles.
REQ-033 A bench SHALL cover: record=27'h7FFFFFF (134_217_727) -> bcd=32'h99999999, ovf=1.
REQ-034 A bench SHALL cover: SCAN_DIV=4, bcd=32'h00000042, macro defined -> digit_en runs 01,02,00x6 with 4 cycles per slot; macro undefined -> 01,02,04,...,80.
REQ-035 A bench SHALL cover: rst=1 at cycle 10 of a conversion -> next cycle busy=0, bcd=0, no done pulse.
REQ-036 A bench SHALL cover: power_now dropped mid-SHIFT -> digit_en=00, IDLE, previous bcd retained; upd with power_now=0 -> ignored.
REQ-037 A bench SHALL cover: upd held high for 100 cycles -> done pulses spaced 30 cycles apart (29 edges per conversion plus 1 cycle in IDLE).
